// File: rtl/alu_wb_collect_queue.sv
// Result-collection and writeback queue: assembles LANES-wide ALU slices into
// 64-thread results and queues them for the register-file arbiter. Optional macro: ALU_VCC_WB_EN.
module alu_wb_collect_queue #(
  parameter int LANES = 16,
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_slice_valid,
  input  logic [LANES*32-1:0]  in_vgpr_slice,
  input  logic [LANES-1:0]     in_sgpr_slice,
  input  logic [LANES-1:0]     in_vcc_slice,
  input  logic [LANES-1:0]     in_exec_slice,
  input  logic [5:0]           in_wfid,
  input  logic [31:0]          in_instr_pc,
  input  logic [9:0]           in_vgpr_dest_addr,
  input  logic [8:0]           in_sgpr_dest_addr,
  input  logic                 in_vgpr_wr_en,
  input  logic                 in_sgpr_wr_en,
  input  logic                 in_vcc_wr_en,
  input  logic                 in_instr_done,
  input  logic                 in_rfa_queue_entry_serviced,
  output logic [2047:0]        out_vgpr_dest_data,
  output logic [63:0]          out_vgpr_wr_mask,
  output logic [63:0]          out_sgpr_dest_data,
  output logic [63:0]          out_exec_wr_vcc_value,
  output logic [5:0]           out_wfid,
  output logic [31:0]          out_instr_pc,
  output logic [9:0]           out_vgpr_dest_addr,
  output logic [8:0]           out_sgpr_dest_addr,
  output logic                 out_vgpr_dest_wr_en,
  output logic                 out_sgpr_dest_wr_en,
  output logic                 out_vcc_wr_en,
  output logic                 out_instr_done,
  output logic                 out_queue_ready,
  output logic                 out_queue_empty,
  output logic                 out_overflow
);

  localparam int PASSES = 64 / LANES;
  localparam int PW     = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam int PTRW   = $clog2(DEPTH);
  localparam int CW     = $clog2(DEPTH + 1);
  localparam int SW     = LANES * 32;

  typedef struct packed {
    logic [5:0]  wfid;
    logic [31:0] pc;
    logic [9:0]  vaddr;
    logic [8:0]  saddr;
    logic        vgpr_wr_en;
    logic        instr_done;
  } meta_t;

  function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] ptr);
    return (ptr == PTRW'(DEPTH - 1)) ? {PTRW{1'b0}} : ptr + PTRW'(1);
  endfunction

  logic [PW-1:0]    pass_r;
  logic             last_pass_s;
  logic             first_pass_s;
  int               lane_base_s;
  logic [2047:0]    asm_vgpr_r;
  logic [63:0]      asm_exec_r;
  meta_t            asm_meta_r;
  meta_t            in_meta_s;
  logic [2047:0]    push_vgpr_s;
  logic [63:0]      push_exec_s;
  meta_t            push_meta_s;
  logic [2047:0]    q_vgpr_r [DEPTH];
  logic [63:0]      q_exec_r [DEPTH];
  meta_t            q_meta_r [DEPTH];
  logic [PTRW-1:0]  wr_ptr_r;
  logic [PTRW-1:0]  rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             overflow_r;
  logic             full_s;
  logic             empty_s;
  logic             complete_s;
  logic             push_s;
  logic             pop_s;

  assign last_pass_s  = (pass_r == PW'(PASSES - 1));
  assign first_pass_s = (pass_r == {PW{1'b0}});
  assign lane_base_s  = int'(pass_r) * LANES;
  assign in_meta_s    = '{wfid: in_wfid, pc: in_instr_pc, vaddr: in_vgpr_dest_addr,
                          saddr: in_sgpr_dest_addr, vgpr_wr_en: in_vgpr_wr_en,
                          instr_done: in_instr_done};

  assign full_s     = (count_r == CW'(DEPTH));
  assign empty_s    = (count_r == {CW{1'b0}});
  assign complete_s = in_slice_valid & last_pass_s;
  assign push_s     = complete_s & ~full_s;
  assign pop_s      = in_rfa_queue_entry_serviced & ~empty_s;

  // Pass counter: position of the next slice within the wavefront
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pass_r <= {PW{1'b0}};
    end else if (in_slice_valid) begin
      pass_r <= last_pass_s ? {PW{1'b0}} : pass_r + PW'(1);
    end else begin
      pass_r <= pass_r;
    end
  end

  // Assembly register: partial vector result and pass-0 metadata
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      asm_vgpr_r <= {2048{1'b0}};
      asm_exec_r <= 64'h0;
      asm_meta_r <= '0;
    end else if (in_slice_valid) begin
      asm_vgpr_r[lane_base_s*32 +: SW] <= in_vgpr_slice;
      asm_exec_r[lane_base_s +: LANES] <= in_exec_slice;
      if (first_pass_s) begin
        asm_meta_r <= in_meta_s;
      end
    end
  end

  // Push image: assembly contents with the final slice merged; with one pass
  // the metadata has to come straight from the inputs
  always_comb begin
    push_vgpr_s = asm_vgpr_r;
    push_exec_s = asm_exec_r;
    push_vgpr_s[lane_base_s*32 +: SW] = in_vgpr_slice;
    push_exec_s[lane_base_s +: LANES] = in_exec_slice;
    if (first_pass_s) begin
      push_meta_s = in_meta_s;
    end else begin
      push_meta_s = asm_meta_r;
    end
  end

  // Queue storage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        q_vgpr_r[i] <= {2048{1'b0}};
        q_exec_r[i] <= 64'h0;
        q_meta_r[i] <= '0;
      end
    end else if (push_s) begin
      q_vgpr_r[wr_ptr_r] <= push_vgpr_s;
      q_exec_r[wr_ptr_r] <= push_exec_s;
      q_meta_r[wr_ptr_r] <= push_meta_s;
    end
  end

  // Pointers, occupancy and sticky overflow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r   <= {PTRW{1'b0}};
      rd_ptr_r   <= {PTRW{1'b0}};
      count_r    <= {CW{1'b0}};
      overflow_r <= 1'b0;
    end else begin
      if (push_s) wr_ptr_r <= ptr_inc(wr_ptr_r);
      if (pop_s)  rd_ptr_r <= ptr_inc(rd_ptr_r);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
      if (complete_s && full_s) overflow_r <= 1'b1;
    end
  end

  assign out_vgpr_dest_data  = q_vgpr_r[rd_ptr_r];
  assign out_vgpr_wr_mask    = q_exec_r[rd_ptr_r];
  assign out_wfid            = q_meta_r[rd_ptr_r].wfid;
  assign out_instr_pc        = q_meta_r[rd_ptr_r].pc;
  assign out_vgpr_dest_addr  = q_meta_r[rd_ptr_r].vaddr;
  assign out_sgpr_dest_addr  = q_meta_r[rd_ptr_r].saddr;
  assign out_vgpr_dest_wr_en = q_meta_r[rd_ptr_r].vgpr_wr_en & ~empty_s;
  assign out_instr_done      = q_meta_r[rd_ptr_r].instr_done & ~empty_s;
  // One slot stays free for the instruction already being assembled
  assign out_queue_ready     = (count_r <= CW'(DEPTH - 2));
  assign out_queue_empty     = empty_s;
  assign out_overflow        = overflow_r;

`ifdef ALU_VCC_WB_EN
  logic [63:0] asm_sgpr_r;
  logic [63:0] asm_vcc_r;
  logic [1:0]  asm_sflag_r;
  logic [63:0] push_sgpr_s;
  logic [63:0] push_vcc_s;
  logic [1:0]  push_sflag_s;
  logic [63:0] q_sgpr_r [DEPTH];
  logic [63:0] q_vcc_r [DEPTH];
  logic [1:0]  q_sflag_r [DEPTH];

  // Scalar/VCC assembly register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      asm_sgpr_r  <= 64'h0;
      asm_vcc_r   <= 64'h0;
      asm_sflag_r <= 2'b00;
    end else if (in_slice_valid) begin
      asm_sgpr_r[lane_base_s +: LANES] <= in_sgpr_slice;
      asm_vcc_r[lane_base_s +: LANES]  <= in_vcc_slice;
      if (first_pass_s) begin
        asm_sflag_r <= {in_sgpr_wr_en, in_vcc_wr_en};
      end
    end
  end

  // Scalar/VCC push image
  always_comb begin
    push_sgpr_s = asm_sgpr_r;
    push_vcc_s  = asm_vcc_r;
    push_sgpr_s[lane_base_s +: LANES] = in_sgpr_slice;
    push_vcc_s[lane_base_s +: LANES]  = in_vcc_slice;
    if (first_pass_s) begin
      push_sflag_s = {in_sgpr_wr_en, in_vcc_wr_en};
    end else begin
      push_sflag_s = asm_sflag_r;
    end
  end

  // Scalar/VCC queue storage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        q_sgpr_r[i]  <= 64'h0;
        q_vcc_r[i]   <= 64'h0;
        q_sflag_r[i] <= 2'b00;
      end
    end else if (push_s) begin
      q_sgpr_r[wr_ptr_r]  <= push_sgpr_s;
      q_vcc_r[wr_ptr_r]   <= push_vcc_s;
      q_sflag_r[wr_ptr_r] <= push_sflag_s;
    end
  end

  assign out_sgpr_dest_data    = q_sgpr_r[rd_ptr_r];
  assign out_exec_wr_vcc_value = q_vcc_r[rd_ptr_r];
  assign out_sgpr_dest_wr_en   = q_sflag_r[rd_ptr_r][1] & ~empty_s;
  assign out_vcc_wr_en         = q_sflag_r[rd_ptr_r][0] & ~empty_s;
`else
  logic unused_vcc_s;
  assign unused_vcc_s          = ^{in_sgpr_slice, in_vcc_slice, in_sgpr_wr_en, in_vcc_wr_en};
  assign out_sgpr_dest_data    = 64'h0;
  assign out_exec_wr_vcc_value = 64'h0;
  assign out_sgpr_dest_wr_en   = 1'b0;
  assign out_vcc_wr_en         = 1'b0;
`endif

endmodule
